// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the programmable
// serial pattern detector.
package seq_det_pkg;

  localparam int DEFAULT_MAX_LEN = 8;
  localparam int DEFAULT_CNT_W   = 8;
  localparam int DEFAULT_LEN_W   =
    $clog2(DEFAULT_MAX_LEN + 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    ARMED
  } state_t;

  typedef struct packed {
    logic [DEFAULT_MAX_LEN-1:0] pattern;
    logic [DEFAULT_LEN_W-1:0]   len;
    logic                       overlap;
  } cfg_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear
// that takes priority over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  // Count up, stick at all-ones, clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/seq_det_prog.sv
// Programmable serial bit-pattern detector with
// run-time pattern/length/overlap and match counter.
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter  int MAX_LEN = DEFAULT_MAX_LEN,
  parameter  int CNT_W   = DEFAULT_CNT_W,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_load_i,
  input  logic [MAX_LEN-1:0] cfg_pattern_i,
  input  logic [LEN_W-1:0]   cfg_len_i,
  input  logic               cfg_overlap_i,
  input  logic               valid_i,
  input  logic               data_i,
  input  logic               cnt_clr_i,
  output logic               detect_o,
  output logic [CNT_W-1:0]   det_cnt_o,
  output logic               busy_o
);

  localparam logic [LEN_W-1:0] MAX_L =
    LEN_W'(MAX_LEN);

  typedef struct packed {
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len;
    logic               overlap;
  } cfg_s;

  cfg_s               cfg_q;
  cfg_s               cfg_d;
  logic [MAX_LEN-2:0] hist_q;
  logic [MAX_LEN-2:0] hist_d;
  logic [MAX_LEN-1:0] hist_acc;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill_q;
  logic [LEN_W-1:0]   fill_d;
  logic [LEN_W-1:0]   fill_acc;
  logic [LEN_W-1:0]   len_ld;
  state_t             state_q;
  state_t             state_d;
  logic               match;
  logic               detect_q;

  // Only the low len bits take part in a compare.
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = LEN_W'(i) < cfg_q.len;
    end
  end

  // Oversized lengths collapse to the full window.
  always_comb begin
    len_ld = (cfg_len_i > MAX_L) ? MAX_L : cfg_len_i;
  end

  // Load beats data; accepted bits shift and match.
  always_comb begin
    cfg_d    = cfg_q;
    hist_d   = hist_q;
    fill_d   = fill_q;
    state_d  = state_q;
    match    = 1'b0;
    hist_acc = {hist_q, data_i};
    fill_acc = (fill_q == MAX_L) ? MAX_L
                                 : fill_q + 1'b1;
    if (cfg_load_i) begin
      cfg_d.pattern = cfg_pattern_i;
      cfg_d.len     = len_ld;
      cfg_d.overlap = cfg_overlap_i;
      hist_d        = '0;
      fill_d        = '0;
      state_d       = IDLE;
    end else if (valid_i) begin
      hist_d = hist_acc[MAX_LEN-2:0];
      fill_d = fill_acc;
      match  = (cfg_q.len != '0) &&
               (fill_acc >= cfg_q.len) &&
               ((hist_acc & mask) ==
                (cfg_q.pattern & mask));
      if (match && !cfg_q.overlap) begin
        fill_d = '0;
      end
      unique case (state_q)
        IDLE, FILL: begin
          if (fill_d == '0) begin
            state_d = IDLE;
          end else if (fill_d >= cfg_q.len) begin
            state_d = ARMED;
          end else begin
            state_d = FILL;
          end
        end
        ARMED: begin
          state_d = (fill_d == '0) ? IDLE : ARMED;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Config, history, fill, FSM and detect registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q.pattern <= '0;
      cfg_q.len     <= '0;
      cfg_q.overlap <= 1'b1;
      hist_q        <= '0;
      fill_q        <= '0;
      state_q       <= IDLE;
      detect_q      <= 1'b0;
    end else begin
      cfg_q    <= cfg_d;
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      state_q  <= state_d;
      detect_q <= match;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc_i(match),
    .clr_i(cnt_clr_i),
    .cnt_o(det_cnt_o)
  );

  assign detect_o = detect_q;
  assign busy_o   = (state_q != IDLE);

endmodule
